inst_trace_buffer: RTL

- Trace capture stage directly upstream of the instruction disassembler.
- Samples (pc, inst) pairs retired by the pipeline into a small FIFO. Presents them one at a time, with a valid/ready handshake, to the disassembler/printer.
- Absorbs bursts when the consumer (testbench $display loop or UART dumper) runs slower than retirement. Counts what it had to drop.

---
 rtl/inst_trace_buffer_pkg.sv | 14 +
 rtl/inst_trace_buffer_fifo_mem.sv | 25 ++
 rtl/inst_trace_buffer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/inst_trace_buffer_pkg.sv
// Shared definitions for the instruction trace buffer: nop encoding and packed entry layout.
// Entry layout, MSB to LSB: {seq, pc, inst}.
package inst_trace_buffer_pkg;

  localparam logic [31:0] TRACE_NOP      = 32'h0000_0000;
  localparam int          TRACE_INST_LSB = 0;
  localparam int          TRACE_PC_LSB   = 32;
  localparam int          TRACE_SEQ_LSB  = 64;

  function automatic int trace_entry_w(input int seq_w);
    return seq_w + 64;
  endfunction

endpackage

// File: rtl/inst_trace_buffer_fifo_mem.sv
// Trace entry storage: DEPTH x WIDTH register array, one write port, one asynchronous read port.
module trace_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 80
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Contents are not reset; validity is tracked by the pointers and count in the parent.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/inst_trace_buffer.sv
// Trace capture FIFO feeding the disassembler, with sequence tags, drop counting and freeze/clear.
// Optional macro TRACE_SKIP_NOP_EN: when defined, captures of the nop word are never pushed.
module inst_trace_buffer
  import inst_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cap_valid,
  input  logic [31:0]                cap_pc,
  input  logic [31:0]                cap_inst,
  input  logic                       freeze,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  output logic [SEQ_W-1:0]           out_seq,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [SEQ_W-1:0]           drop_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = trace_entry_w(SEQ_W);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [SEQ_W-1:0]   seq_ctr_r;
  logic               overflow_r;
  logic [SEQ_W-1:0]   drop_cnt_r;

  logic               is_nop_s;
  logic               push_s;
  logic               pop_s;
  logic               accept_s;
  logic               drop_s;
  logic               full_s;
  logic               empty_s;
  logic [ENTRY_W-1:0] wr_entry_s;
  logic [ENTRY_W-1:0] rd_entry_s;

`ifdef TRACE_SKIP_NOP_EN
  assign is_nop_s = (cap_inst == TRACE_NOP);
`else
  assign is_nop_s = 1'b0;
`endif

  assign full_s     = (count_r == FULL_CNT);
  assign empty_s    = (count_r == {CNT_W{1'b0}});
  assign push_s     = cap_valid && !freeze && !clear && !is_nop_s;
  assign pop_s      = !empty_s && out_ready && !clear;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign accept_s   = push_s && (!full_s || pop_s);
  assign drop_s     = push_s && full_s && !pop_s;
  assign wr_entry_s = {seq_ctr_r, cap_pc, cap_inst};

  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (accept_s),
    .waddr (wr_ptr_r),
    .wdata (wr_entry_s),
    .raddr (rd_ptr_r),
    .rdata (rd_entry_s)
  );

  // Pointer, occupancy, sequence and drop bookkeeping; clear keeps seq_ctr so tags stay monotonic.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      seq_ctr_r  <= {SEQ_W{1'b0}};
      overflow_r <= 1'b0;
      drop_cnt_r <= {SEQ_W{1'b0}};
    end else if (clear) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
      drop_cnt_r <= {SEQ_W{1'b0}};
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (accept_s && !pop_s) begin
        count_r <= count_r + CNT_W'(1);
      end else if (pop_s && !accept_s) begin
        count_r <= count_r - CNT_W'(1);
      end
      if (push_s) begin
        seq_ctr_r <= seq_ctr_r + SEQ_W'(1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != {SEQ_W{1'b1}}) begin
          drop_cnt_r <= drop_cnt_r + SEQ_W'(1);
        end
      end
    end
  end

  // Head fields fall through from storage; forced to zero when empty so the disassembler sees a nop.
  always_comb begin
    out_pc   = 32'h0000_0000;
    out_inst = TRACE_NOP;
    out_seq  = {SEQ_W{1'b0}};
    if (!empty_s) begin
      out_pc   = rd_entry_s[TRACE_PC_LSB +: 32];
      out_inst = rd_entry_s[TRACE_INST_LSB +: 32];
      out_seq  = rd_entry_s[TRACE_SEQ_LSB +: SEQ_W];
    end else begin
      out_pc   = 32'h0000_0000;
      out_inst = TRACE_NOP;
      out_seq  = {SEQ_W{1'b0}};
    end
  end

  assign out_valid = !empty_s;
  assign count     = count_r;
  assign full      = full_s;
  assign empty     = empty_s;
  assign overflow  = overflow_r;
  assign drop_cnt  = drop_cnt_r;

endmodule
